// File: rtl/dds_rom_scheduler_pkg.sv
// Shared DDS constants: ROM geometry, default channel count, channel-index width
// and the config-port state encoding.
`ifndef ROM_PHASE_BIT
`define ROM_PHASE_BIT 10
`endif
`ifndef ROM_AMPLITUDE_BIT
`define ROM_AMPLITUDE_BIT 12
`endif

package dds_rom_scheduler_pkg;
  localparam int ROM_PHASE_BIT     = `ROM_PHASE_BIT;
  localparam int ROM_AMPLITUDE_BIT = `ROM_AMPLITUDE_BIT;
  localparam int ROM_PHASE_MAX_VAL = (1 << ROM_PHASE_BIT) - 1;
  localparam int DDS_N_CH          = 4;
  localparam int CH_IDX_W          = 4;

  typedef enum logic [1:0] {
    CFG_IDLE    = 2'd0,
    CFG_PENDING = 2'd1,
    CFG_DROP    = 2'd2
  } cfg_state_t;
endpackage

// File: rtl/dds_phase_acc_bank.sv
// Per-channel phase accumulator / FTW / enable storage with one slot-indexed
// read-modify-write port. Per-channel phase offsets exist only with PHASE_OFFSET_EN.
module dds_phase_acc_bank
  import dds_rom_scheduler_pkg::*;
#(
  parameter int N_CH    = DDS_N_CH,
  parameter int ACC_W   = 32,
  parameter int PHASE_W = ROM_PHASE_BIT,
  parameter int SLOT_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SLOT_W-1:0]  slot,
  input  logic               sync_clr,
  input  logic               wr,
  input  logic [ACC_W-1:0]   wr_ftw,
  input  logic               wr_en,
`ifdef PHASE_OFFSET_EN
  input  logic [PHASE_W-1:0] wr_poff,
`endif
  output logic               rd_en,
  output logic [PHASE_W-1:0] rd_phase
);

  logic [ACC_W-1:0] acc [N_CH];
  logic [ACC_W-1:0] ftw [N_CH];
  logic [N_CH-1:0]  en;
  logic [ACC_W-1:0] cur_acc;
  logic [ACC_W-1:0] cur_ftw;

  // A config landing on this slot takes effect for this very update.
  assign cur_acc = sync_clr ? '0 : acc[slot];
  assign cur_ftw = wr ? wr_ftw : ftw[slot];
  assign rd_en   = wr ? wr_en : en[slot];

`ifdef PHASE_OFFSET_EN
  logic [PHASE_W-1:0] poff [N_CH];
  logic [PHASE_W-1:0] cur_poff;
  assign cur_poff = wr ? wr_poff : poff[slot];
  assign rd_phase = cur_acc[ACC_W-1 -: PHASE_W] + cur_poff;
`else
  assign rd_phase = cur_acc[ACC_W-1 -: PHASE_W];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        acc[i] <= '0;
        ftw[i] <= '0;
`ifdef PHASE_OFFSET_EN
        poff[i] <= '0;
`endif
      end
      en <= '0;
    end else begin
      if (sync_clr) begin
        for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      end
      acc[slot] <= rd_en ? cur_acc + cur_ftw : '0;
      if (wr) begin
        ftw[slot] <= wr_ftw;
        en[slot]  <= wr_en;
`ifdef PHASE_OFFSET_EN
        poff[slot] <= wr_poff;
`endif
      end
    end
  end

endmodule

// File: rtl/dds_rom_scheduler.sv
// Round-robin scheduler sharing one registered waveform ROM across N_CH DDS channels.
// Define PHASE_OFFSET_EN to add per-channel phase offsets (cfg_poff port).
//
// state       | meaning
// CFG_IDLE    | holding register empty, cfg_ready high
// CFG_PENDING | write held until its channel's slot comes round
// CFG_DROP    | out-of-range channel accepted, discarded this clock
module dds_rom_scheduler
  import dds_rom_scheduler_pkg::*;
#(
  parameter int N_CH    = DDS_N_CH,
  parameter int ACC_W   = 32,
  parameter int PHASE_W = ROM_PHASE_BIT,
  parameter int AMP_W   = ROM_AMPLITUDE_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_IDX_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]      cfg_ftw,
  input  logic                  cfg_en,
`ifdef PHASE_OFFSET_EN
  input  logic [PHASE_W-1:0]    cfg_poff,
`endif
  input  logic                  phase_sync,
  output logic [PHASE_W-1:0]    rom_phase,
  input  logic [AMP_W-1:0]      rom_value,
  output logic [N_CH*AMP_W-1:0] ch_value,
  output logic [N_CH-1:0]       ch_strobe
);

  localparam int SLOT_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  cfg_state_t          state, state_nxt;
  logic [SLOT_W-1:0]   slot;
  logic [CH_IDX_W-1:0] pend_ch;
  logic [ACC_W-1:0]    pend_ftw;
  logic                pend_en;
`ifdef PHASE_OFFSET_EN
  logic [PHASE_W-1:0]  pend_poff;
`endif
  logic                cfg_apply;
  logic                sync_armed;
  logic                sync_clr;
  logic                acc_en;
  logic [PHASE_W-1:0]  acc_phase;
  logic [SLOT_W-1:0]   tag0, tag1;
  logic                v0, v1;

  assign sync_clr = sync_armed && (slot == '0);

  dds_phase_acc_bank #(
    .N_CH    (N_CH),
    .ACC_W   (ACC_W),
    .PHASE_W (PHASE_W),
    .SLOT_W  (SLOT_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .slot     (slot),
    .sync_clr (sync_clr),
    .wr       (cfg_apply),
    .wr_ftw   (pend_ftw),
    .wr_en    (pend_en),
`ifdef PHASE_OFFSET_EN
    .wr_poff  (pend_poff),
`endif
    .rd_en    (acc_en),
    .rd_phase (acc_phase)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= CFG_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    cfg_apply = 1'b0;
    case (state)
      CFG_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_nxt = (int'(cfg_ch) < N_CH) ? CFG_PENDING : CFG_DROP;
      end
      CFG_PENDING: begin
        if (pend_ch == CH_IDX_W'(slot)) begin
          cfg_apply = 1'b1;
          state_nxt = CFG_IDLE;
        end
      end
      CFG_DROP: state_nxt = CFG_IDLE;
      default:  state_nxt = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot       <= '0;
      sync_armed <= 1'b0;
      pend_ch    <= '0;
      pend_ftw   <= '0;
      pend_en    <= 1'b0;
`ifdef PHASE_OFFSET_EN
      pend_poff  <= '0;
`endif
      rom_phase  <= '0;
      tag0       <= '0;
      tag1       <= '0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      ch_value   <= '0;
      ch_strobe  <= '0;
    end else begin
      slot <= (slot == SLOT_W'(N_CH - 1)) ? '0 : slot + SLOT_W'(1);
      // Pulses arriving while armed (including the clearing cycle) are absorbed.
      sync_armed <= sync_armed ? !sync_clr : phase_sync;
      if (cfg_valid && cfg_ready) begin
        pend_ch   <= cfg_ch;
        pend_ftw  <= cfg_ftw;
        pend_en   <= cfg_en;
`ifdef PHASE_OFFSET_EN
        pend_poff <= cfg_poff;
`endif
      end
      if (acc_en) rom_phase <= acc_phase;
      tag0      <= slot;
      v0        <= acc_en;
      tag1      <= tag0;
      v1        <= v0;
      ch_strobe <= '0;
      if (v1) begin
        ch_value[tag1*AMP_W +: AMP_W] <= rom_value;
        ch_strobe <= N_CH'(1) << tag1;
      end
    end
  end

endmodule

// File: tb/tb_dds_rom_scheduler.sv
// Scoreboard bench for dds_rom_scheduler: per-channel expected-amplitude queues
// filled by the stimulus, drained by a strobe monitor.
module tb_dds_rom_scheduler;
  import dds_rom_scheduler_pkg::*;

  localparam int N_CH    = 4;
  localparam int ACC_W   = 32;
  localparam int PHASE_W = ROM_PHASE_BIT;
  localparam int AMP_W   = ROM_AMPLITUDE_BIT;
  localparam int NSEQ    = 200;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cfg_valid = 1'b0;
  logic                  cfg_ready;
  logic [CH_IDX_W-1:0]   cfg_ch = '0;
  logic [ACC_W-1:0]      cfg_ftw = '0;
  logic                  cfg_en = 1'b0;
  logic                  phase_sync = 1'b0;
  logic [PHASE_W-1:0]    rom_phase;
  logic [AMP_W-1:0]      rom_value = '0;
  logic [N_CH*AMP_W-1:0] ch_value;
  logic [N_CH-1:0]       ch_strobe;
`ifdef PHASE_OFFSET_EN
  logic [PHASE_W-1:0]    cfg_poff = '0;
`endif

  dds_rom_scheduler #(
    .N_CH(N_CH), .ACC_W(ACC_W), .PHASE_W(PHASE_W), .AMP_W(AMP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_ftw    (cfg_ftw),
    .cfg_en     (cfg_en),
`ifdef PHASE_OFFSET_EN
    .cfg_poff   (cfg_poff),
`endif
    .phase_sync (phase_sync),
    .rom_phase  (rom_phase),
    .rom_value  (rom_value),
    .ch_value   (ch_value),
    .ch_strobe  (ch_strobe)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int n_strobes = 0;
  int cyc = 0;
  int tb_slot = 0;
  logic [AMP_W-1:0] q [N_CH][$];
  logic [AMP_W-1:0] mon_exp;
  logic [ACC_W-1:0] ftw_m [N_CH];
  logic             en_m [N_CH];

  function automatic logic [AMP_W-1:0] amp(input logic [PHASE_W-1:0] p);
    return AMP_W'(p) ^ AMP_W'(12'hA53);
  endfunction

  function automatic logic [PHASE_W-1:0] phase_of(input int i, input logic [ACC_W-1:0] f);
    logic [ACC_W-1:0] a;
    a = f * ACC_W'(i);
    return a[ACC_W-1 -: PHASE_W];
  endfunction

  function automatic void check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_seq(input int k, input logic [ACC_W-1:0] f);
    for (int i = 0; i < NSEQ; i++) q[k].push_back(amp(phase_of(i, f)));
  endfunction

  function automatic int apply_delta(input int ch, input int s);
    return ((ch - s - 1 + 2 * N_CH) % N_CH) + 1;
  endfunction

  // Registered ROM: value appears one clock after the address.
  always @(posedge clk) rom_value <= amp(rom_phase);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    tb_slot <= rst ? 0 : (tb_slot + 1) % N_CH;
  end

  always @(negedge clk) begin
    if (ch_strobe != '0) begin
      n_strobes++;
      check("strobe_onehot", longint'($onehot(ch_strobe)), 1);
      for (int k = 0; k < N_CH; k++) begin
        if (ch_strobe[k]) begin
          if (q[k].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_unexpected ch%0d: got strobe at cycle %0d, expected none", k, cyc);
          end else begin
            mon_exp = q[k].pop_front();
            check($sformatf("ch%0d_value@%0d", k, cyc), longint'(ch_value[k*AMP_W +: AMP_W]), longint'(mon_exp));
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_slot(input int s);
    int g = 0;
    while (tb_slot != s && g < 2 * N_CH) begin
      tick(1);
      g++;
    end
  endtask

  task automatic cfg_write(input int ch, input logic [ACC_W-1:0] f, input logic e,
                           input int want_slot, output int t_xfer, output int s_xfer);
    int g = 0;
    if (want_slot >= 0) goto_slot(want_slot);
    cfg_valid = 1'b1;
    cfg_ch    = CH_IDX_W'(ch);
    cfg_ftw   = f;
    cfg_en    = e;
    @(negedge clk);
    while (!cfg_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!cfg_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL cfg_ready_timeout ch%0d: ready stayed low, expected high", ch);
    end
    t_xfer = cyc;
    s_xfer = tb_slot;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_strobe(input int k, input int exp_cyc);
    int n = 0;
    @(negedge clk);
    while (!ch_strobe[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ch_strobe[k]) begin
      n_tests++;
      n_fail++;
      $display("FAIL strobe_timeout ch%0d: no strobe, expected one at cycle %0d", k, exp_cyc);
    end else begin
      check($sformatf("ch%0d_latency", k), longint'(cyc), longint'(exp_cyc));
    end
  endtask

  initial begin
    int t, s, t2, s2, a_en, a_dis, a0, a3, a2, p, z, cnt, r, strobes_at_r;
    for (int k = 0; k < N_CH; k++) begin
      ftw_m[k] = '0;
      en_m[k]  = 1'b0;
    end

    // Reset, then idle with nothing configured.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_rom_phase", longint'(rom_phase), 0);
    check("reset_cfg_ready", longint'(cfg_ready), 1);
    tick(40);
    check("idle_strobe_count", longint'(n_strobes), 0);
    check("idle_ch_value", longint'(ch_value), 0);
    check("idle_cfg_ready", longint'(cfg_ready), 1);

    // ch1 at ftw=2^22: phase steps by one per service.
    ftw_m[1] = 32'h0040_0000;
    en_m[1]  = 1'b1;
    push_seq(1, ftw_m[1]);
    cfg_write(1, ftw_m[1], 1'b1, -1, t, s);
    a_en = t + apply_delta(1, s);
    goto_cyc(a_en + 1);
    check("ch1_phase0", longint'(rom_phase), 0);
    wait_strobe(1, a_en + 3);
    goto_cyc(a_en + 5);
    check("ch1_phase1", longint'(rom_phase), 1);
    wait_strobe(1, a_en + 7);
    goto_cyc(a_en + 9);
    check("ch1_phase2", longint'(rom_phase), 2);
    goto_cyc(a_en + 20);
    cfg_write(1, ftw_m[1], 1'b0, -1, t, s);
    en_m[1] = 1'b0;
    a_dis = t + apply_delta(1, s);
    goto_cyc(a_dis + 6);
    check("ch1_service_count", longint'(q[1].size()), longint'(NSEQ - (a_dis - a_en) / 4));
    q[1].delete();

    // Back-to-back configs issued at slot 1: ch0 then ch3.
    ftw_m[0] = 32'h00C0_0000;
    ftw_m[3] = 32'h0080_0000;
    en_m[0]  = 1'b1;
    en_m[3]  = 1'b1;
    push_seq(0, ftw_m[0]);
    push_seq(3, ftw_m[3]);
    cfg_write(0, ftw_m[0], 1'b1, 1, t, s);
    check("b2b_first_slot", longint'(s), 1);
    a0 = t + apply_delta(0, s);
    check("b2b_ready_low", longint'(cfg_ready), 0);
    cfg_write(3, ftw_m[3], 1'b1, -1, t2, s2);
    check("b2b_second_xfer", longint'(t2), longint'(a0 + 1));
    a3 = t2 + apply_delta(3, s2);
    check("b2b_ch3_apply", longint'(a3), longint'(t + 6));
    wait_strobe(0, a0 + 3);
    wait_strobe(3, a3 + 3);

    // Out-of-range channel: ready low for exactly one clock, no effect.
    tick(3);
    cfg_write(9, 32'h1234_5678, 1'b1, -1, t, s);
    check("drop_ready_low", longint'(cfg_ready), 0);
    goto_cyc(t + 2);
    check("drop_ready_back", longint'(cfg_ready), 1);

    // ch2 counting down: phase 0, 1023, 1022 with accumulator wrap.
    ftw_m[2] = 32'hFFC0_0000;
    en_m[2]  = 1'b1;
    push_seq(2, ftw_m[2]);
    cfg_write(2, ftw_m[2], 1'b1, -1, t, s);
    a2 = t + apply_delta(2, s);
    goto_cyc(a2 + 1);
    check("ch2_phase0", longint'(rom_phase), 0);
    wait_strobe(2, a2 + 3);
    goto_cyc(a2 + 5);
    check("ch2_phase1", longint'(rom_phase), ROM_PHASE_MAX_VAL);
    goto_cyc(a2 + 9);
    check("ch2_phase2", longint'(rom_phase), ROM_PHASE_MAX_VAL - 1);
    tick(30);

    // phase_sync at slot 1; clear lands at the next slot 0 (cycle z).
    goto_slot(1);
    p = cyc;
    z = p + 3;
    for (int k = 0; k < N_CH; k++) begin
      if (en_m[k]) begin
        cnt = 0;
        for (int c = p - 3; c < z; c++)
          if (((tb_slot + c - p + 2 * N_CH) % N_CH) == k) cnt++;
        while (q[k].size() > cnt) void'(q[k].pop_back());
        push_seq(k, ftw_m[k]);
      end
    end
    phase_sync = 1'b1;
    tick(1);
    phase_sync = 1'b0;
    goto_cyc(z);
    phase_sync = 1'b1;
    tick(1);
    phase_sync = 1'b0;
    check("sync_ch0_phase", longint'(rom_phase), 0);
    wait_strobe(0, z + 3);
    check("sync_ch2_phase", longint'(rom_phase), 0);
    wait_strobe(2, z + 5);
    wait_strobe(3, z + 6);
    tick(40);

    // Reset with lookups in flight and a ch1 config pending.
    cfg_write(1, 32'h0040_0000, 1'b1, 2, t, s);
    check("rst_pending_ready", longint'(cfg_ready), 0);
    r = cyc;
    for (int k = 0; k < N_CH; k++) begin
      cnt = (en_m[k] && k == (tb_slot + 1) % N_CH) ? 1 : 0;
      while (q[k].size() > cnt) void'(q[k].pop_back());
      en_m[k] = 1'b0;
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    strobes_at_r = n_strobes;
    check("rst_ch_value", longint'(ch_value), 0);
    check("rst_cfg_ready", longint'(cfg_ready), 1);
    check("rst_rom_phase", longint'(rom_phase), 0);
    check("rst_cycle", longint'(cyc), longint'(r + 1));
    tick(40);
    check("rst_no_strobes", longint'(n_strobes), longint'(strobes_at_r));
    check("rst_ch_value_hold", longint'(ch_value), 0);
    for (int k = 0; k < N_CH; k++)
      check($sformatf("rst_q%0d_empty", k), longint'(q[k].size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_rom_scheduler.md
Name: dds_rom_scheduler

Overview:
Time-multiplexes one registered waveform ROM read port (phase in, 1-cycle registered value out) across N_CH independent DDS channels. Each channel owns a phase accumulator and a frequency tuning word (FTW). A round-robin slot counter issues one ROM lookup per clock and routes the returned amplitude to that channel's output register with a strobe. Configuration arrives over a valid/ready write port and is applied only at the target channel's slot.

Parameters:
N_CH, 4, number of channels (2..16)
ACC_W, 32, phase accumulator / FTW width
PHASE_W, `ROM_PHASE_BIT, ROM address width; top PHASE_W bits of the accumulator
AMP_W, `ROM_AMPLITUDE_BIT, ROM data width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_valid  in  1  config write request
cfg_ready  out  1  config holding register empty
cfg_ch  in  4  target channel index
cfg_ftw  in  ACC_W  new tuning word
cfg_en  in  1  channel enable
phase_sync  in  1  one-cycle pulse: zero all accumulators
rom_phase  out  PHASE_W  registered ROM address
rom_value  in  AMP_W  ROM data, valid 1 clk after rom_phase
ch_value  out  N_CH*AMP_W  per-channel sample; channel k at [k*AMP_W +: AMP_W]
ch_strobe  out  N_CH  one-cycle pulse per channel update

Behaviour:
- Reset values: slot=0, all acc/ftw/en=0, rom_phase=0, ch_value=0, ch_strobe=0, cfg_ready=1, pending config dropped, pipeline valid bits cleared. rst mid-operation discards in-flight lookups; no strobe is emitted for them.
- Slot counter: increments every clock and wraps N_CH-1 -> 0. Each channel is serviced exactly once per N_CH clocks.
- Stage S0, slot=k:
  - If en[k]=1: rom_phase <= acc[k][ACC_W-1 -: PHASE_W] and acc[k] <= acc[k]+ftw[k]. Modulo 2^ACC_W; carry discarded.
  - Set tag0<=k and v0<=1. If en[k]=0: acc[k]<=0 and v0<=0; rom_phase holds.
- Stage S1: tag1<=tag0, v1<=v0. The ROM registers its value on the same edge.
- Stage S2: if v1=1, ch_value[tag1]<=rom_value and ch_strobe[tag1]=1 for exactly one clock. Otherwise no strobe.
- Latency: 3 clocks from slot k to the ch_value[k] update. Disabled channels hold their last ch_value.
- Config handshake:
  - Transfer occurs when cfg_valid and cfg_ready are both high. The transfer latches {ch, ftw, en} and drops cfg_ready.
  - The pending write is applied in the cycle where slot==pending ch. That cycle's accumulator update uses the NEW ftw; if new en=0, acc is cleared.
  - cfg_ready returns to 1 the clock after application. Worst-case ready-low time: N_CH clocks.
  - cfg_ch>=N_CH: accepted, then discarded the next clock (ready low for 1 clock).
- phase_sync:
  - Arms a flag. At the next slot==0, all accumulators are cleared before that cycle's addition; channel 0 reads phase 0 in that cycle.
  - Flag clears after use. A repeated pulse while armed is absorbed.
  - A simultaneous config apply and sync clear: the clear wins for acc, and the config still updates ftw/en.

Optional Feature:
PHASE_OFFSET_EN
- Defined: adds input cfg_poff (PHASE_W) latched with each config. rom_phase = acc top bits + poff[k], mod 2^PHASE_W. Offsets reset to 0.
- Undefined: the port is absent and there is no adder in the S0 path.

Decomposition:
- Shared package/header dds_defs: ROM_PHASE_BIT, ROM_AMPLITUDE_BIT, ROM_PHASE_MAX_VAL, DDS_N_CH default, channel-index width constant.
- Sub-module dds_phase_acc_bank: per-channel acc/ftw/en(/poff) storage with a slot-indexed read/update port. The scheduler keeps the slot counter, config FSM (IDLE/PENDING/DROP) and tag pipeline.

Test Plan:
- Reset, no config, 40 clocks -> ch_strobe never asserts; all ch_value=0; cfg_ready=1.
- Configure ch1 ftw=2^22, en=1 (ACC_W=32, PHASE_W=10) -> ch_strobe[1] every 4 clocks; successive rom_phase for ch1 = 0,1,2,…; 3-clock slot-to-strobe latency.
- Back-to-back configs ch0 then ch3 while slot=1 -> second held (cfg_ready=0) until ch0 applied at slot 0; ch3 applied at next slot 3.
- ftw=0xFFC00000 on ch2 -> phase sequence 0,1023,1022,…; accumulator wraps with no glitch.
- Mid-stream phase_sync -> at next slot 0 all enabled channels restart at phase 0; aligned strobes follow.
- rst asserted between S0 and S2 -> no strobe for the in-flight lookup; outputs 0; pending config lost; cfg_ready=1 after rst deasserts.
